// File: rtl/kernel_a_vout_collect.sv
// Output collector for a stallable pipeline: absorbs results into a
// small FIFO, drives stall upstream, streams downstream, counts a run.
module kernel_a_vout_collect #(
  parameter int DATAW  = 32,
  parameter int DEPTH  = 4,
  parameter int NITEMS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATAW-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     stall,
  output logic [DATAW-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NITEMS + 1);
  localparam logic [AW:0]   DEPTH_F  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] NITEMS_C = CW'(NITEMS);
  localparam logic [CW-1:0] LAST_C   = CW'(NITEMS - 1);

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_fill;
  logic [CW-1:0]    r_acc;
  logic [CW-1:0]    r_pop;
  logic             r_done;

  logic w_full;
  logic w_lim;
  logic w_push;
  logic w_pop;

  // stall depends on registered state only, never on this cycle's handshakes
  assign w_full  = (r_fill == DEPTH_F);
  assign w_lim   = (r_acc == NITEMS_C);
  assign stall   = !rst | w_full | w_lim;
  assign w_push  = in_valid & !stall;
  assign m_valid = (r_fill != '0);
  assign w_pop   = m_valid & m_ready;
  assign m_data  = r_mem[r_rp];
  assign fill    = r_fill;
  assign done    = r_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
      r_acc  <= '0;
      r_pop  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
        if (!w_lim) begin
          r_acc <= r_acc + CW'(1);
        end
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
        if (r_pop != NITEMS_C) begin
          r_pop <= r_pop + CW'(1);
        end
        if (r_pop == LAST_C) begin
          r_done <= 1'b1;
        end
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW + 1)'(1);
        2'b01:   r_fill <= r_fill - (AW + 1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_a_vout_collect.sv
// Bench for kernel_a_vout_collect: directed scenarios plus random runs,
// checked against a queue-based reference model.
module tb_kernel_a_vout_collect;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int N  = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          stall;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          done;
  logic [2:0]    fill;

  kernel_a_vout_collect #(
    .DATAW(DW), .DEPTH(DP), .NITEMS(N)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .stall(stall),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .done(done), .fill(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: FIFO contents as a queue plus run counters
  logic [DW-1:0] q[$];
  int  acc;
  int  popc;
  bit  mdone;
  int  n_cmp;
  int  n_err;
  bit  t;
  int  k;
  logic [DW-1:0] d;

  task automatic cmp(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_stall();
    return !rst || q.size() == DP || acc == N;
  endfunction

  task automatic model_clear();
    q.delete();
    acc   = 0;
    popc  = 0;
    mdone = 1'b0;
  endtask

  task automatic chk();
    cmp("stall", stall, exp_stall());
    cmp("m_valid", m_valid, q.size() != 0);
    cmp("fill", fill, q.size());
    cmp("done", done, mdone);
    if (q.size() != 0) cmp("m_data", m_data, q[0]);
  endtask

  // one clock cycle, entered and left just after a falling edge
  task automatic cyc(input bit v, input logic [DW-1:0] dd, input bit r,
                     output bit took);
    bit pp;
    in_valid = v;
    in_data  = dd;
    m_ready  = r;
    #1;
    chk();
    took = v && !exp_stall();
    pp   = rst && r && q.size() != 0;
    @(posedge clk);
    if (pp) begin
      void'(q.pop_front());
      popc++;
      if (popc == N) mdone = 1'b1;
    end
    if (took) begin
      q.push_back(dd);
      acc++;
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    cmp("rst_fill", fill, 0);
    cmp("rst_valid", m_valid, 1'b0);
    cmp("rst_stall", stall, 1'b1);
    cmp("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_done(input int budget, input bit rnd);
    bit v;
    bit r;
    logic [DW-1:0] dd;
    dd = $urandom;
    for (int c = 0; c < budget && !mdone; c++) begin
      v = rnd ? ($urandom % 4 != 0) : 1'b1;
      r = rnd ? ($urandom % 3 != 0) : 1'b1;
      cyc(v, dd, r, t);
      if (t) dd = $urandom;
    end
    cmp("run_done", done, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, dd, 1'b1, t);
      cmp("post_valid", m_valid, 1'b0);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    m_ready  = 1'b0;
    model_clear();
    #2;
    chk();
    @(negedge clk);
    rst = 1'b1;

    // empty pop: m_ready ignored while empty
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, '0, 1'b1, t);
      cmp("empty_fill", fill, 0);
    end

    // streaming 0x10..0x17 with m_ready held high
    k = 0;
    for (int c = 0; c < 40 && !mdone; c++) begin
      cyc(k < N, 32'h10 + k, 1'b1, t);
      if (t) k++;
    end
    cmp("stream_done", done, 1'b1);
    cyc(1'b1, 32'h99, 1'b1, t);
    cmp("stream_lim", stall, 1'b1);

    // backpressure: fill to 4, hold 0xA4, release one pop
    async_reset();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 32'hA0 + k, 1'b0, t);
      if (t) k++;
    end
    cmp("bp_full", fill, 4);
    cmp("bp_stall", stall, 1'b1);
    cyc(1'b1, 32'hA0 + k, 1'b1, t);
    cmp("bp_fill3", fill, 3);
    cmp("bp_unstall", stall, 1'b0);
    cyc(1'b1, 32'hA0 + k, 1'b0, t);
    cmp("bp_took", fill, 4);
    cmp("bp_head", m_data, 32'hA1);
    run_to_done(200, 1'b1);

    // simultaneous push/pop at fill 2 across pointer wrap, then run limit
    async_reset();
    cyc(1'b1, 32'hB0, 1'b0, t);
    cyc(1'b1, 32'hB1, 1'b0, t);
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 32'hB2 + c, 1'b1, t);
      cmp("pp_fill", fill, 2);
    end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 32'hC0 + c, 1'b1, t);
    end
    cmp("lim_done", done, 1'b1);
    cmp("lim_stall", stall, 1'b1);

    // async reset mid-run with fill 3, then a fresh run
    async_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 32'hD0 + c, 1'b0, t);
    end
    cmp("mid_fill3", fill, 3);
    async_reset();
    run_to_done(200, 1'b0);

    // random runs
    for (int n = 0; n < 4; n++) begin
      async_reset();
      run_to_done(300, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_a_vout_collect.md
# kernel_A_vout_collect

Output-side collector for a stallable leaf-map pipeline. It is the consumer end of the pipeline's registered `out1`/`stall` interface. It absorbs pipeline results into a small FIFO and drives `stall` back into every pipeline stage whenever it cannot accept a word. Results are presented downstream on a valid/ready stream. The block counts a fixed number of items per run and raises a sticky `done`.

## Interface
Parameters:
- DATAW, 32, data width; matches the pipeline's `out1` width.
- DEPTH, 4, FIFO depth in words; power of two, ≥ 2.
- NITEMS, 1024, words per run; ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is synchronous to `clk` (synchronised upstream).
- in_data  in  DATAW  pipeline result, the `out1` of the last stage.
- in_valid  in  1  valid tag travelling with `in_data` through the pipeline.
- stall  out  1  hold request to all pipeline stages.
- m_data  out  DATAW  downstream data; equals the FIFO head.
- m_valid  out  1  FIFO non-empty and run not finished.
- m_ready  in  1  downstream accept.
- done  out  1  sticky; all NITEMS words delivered downstream.
- fill  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- State:
  - FIFO storage: DEPTH×DATAW.
  - Read and write pointers: clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy `fill`: 0..DEPTH.
  - `acc_cnt` and `pop_cnt`: clog2(NITEMS+1) bits, saturate at NITEMS.
  - `done` register.
- stall = (!rst) | (fill == DEPTH) | (acc_cnt == NITEMS).
  - Combinational from registers only. No path from `m_ready`, `in_valid` or `in_data`.
- push = in_valid & !stall.
  - On push: write `in_data` at the write pointer, increment the pointer, increment `acc_cnt`.
- A word presented while `stall`=1 is not taken. The pipeline holds it, because the leaf stages keep `out1` under stall. It is re-presented unchanged and taken on the first edge with `stall`=0.
- m_valid = (fill != 0).
- m_data = storage[rd_ptr], combinational read of the head.
- pop = m_valid & m_ready.
  - On pop: increment the read pointer, increment `pop_cnt`.
- fill update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push & pop, or on neither.
- Boundary behaviour:
  - Full (`fill`=DEPTH): `stall`=1, so there is no push. A pop in this cycle gives `fill`=DEPTH−1 next cycle, and `stall` drops in that cycle.
  - Empty: `m_valid`=0. `m_ready` is ignored; no pointer or counter change.
  - Push & pop in the same cycle at non-empty, non-full: both happen. Push and pop never target the same entry.
  - `acc_cnt` reaches NITEMS: `stall` stays 1 for the rest of the run, so no extra words enter. The FIFO continues to drain.
  - Pointer wrap: DEPTH−1 → 0 with no bubble.
- done: set on the edge where `pop_cnt` becomes NITEMS. Held until reset. At that point `fill`=0, so `m_valid`=0.
- Reset mid-run: pointers, `fill`, both counters and `done` clear immediately. `stall` asserts immediately. FIFO contents are discarded; storage itself needs no reset.

## Timing
- Reset values: `stall`=1 (while `rst`=0), `m_valid`=0, `done`=0, `fill`=0.
  - `m_data`=don't-care.
  - `stall` becomes 0 combinationally once `rst`=1, given NITEMS ≥ 1.
- Latency, input to output: a word pushed at edge t is visible on `m_data` with `m_valid`=1 at t+ (same cycle after the edge), if the FIFO was empty. Minimum one cycle from presentation to acceptance downstream.
- Throughput: one word per cycle sustained when `m_ready`=1 continuously.
- `stall` reacts one edge after the event that changes `fill` or `acc_cnt`. It never depends combinationally on the current cycle's handshakes.
- `done` rises one edge after the final pop handshake is sampled.

## Test plan
- Streaming, DEPTH=4, NITEMS=8:
  - Stimulus: 8 valid words 0x10..0x17 back-to-back, `m_ready`=1.
  - Required: `m_data` sequence 0x10..0x17, `stall` never 1 mid-run, `done`=1 one edge after the 8th pop.
- Backpressure:
  - Stimulus: `m_ready`=0, present words 0xA0,0xA1,…
  - Required: `fill` steps 1..4, `stall`=1 from the edge `fill` hits 4. 0xA4 is held on `in_data` and not accepted.
  - Then: raise `m_ready` one cycle. Required: `fill`=3, `stall`=0, 0xA4 accepted next edge.
- Simultaneous push/pop at `fill`=2 with `m_ready`=1 and `in_valid`=1 for 10 cycles:
  - Required: `fill` stays 2 and order is preserved across pointer wrap.
- Run limit, NITEMS=3:
  - Stimulus: offer 5 words.
  - Required: exactly 3 accepted, `stall` held 1 after the 3rd, `done` after the 3rd pop, `m_valid`=0 thereafter.
- Empty pop: `m_ready`=1 with `fill`=0 for 5 cycles.
  - Required: no change in `fill` or `pop_cnt`, `m_valid`=0.
- Async reset mid-run:
  - Stimulus: drop `rst` between edges with `fill`=3.
  - Required: `fill`=0, `m_valid`=0 and `stall`=1 immediately, without waiting for a clock edge. After release, a fresh run of NITEMS completes with the correct `done`.
